// File: rtl/uart_pkg.sv
// Shared definitions for the MMIO UART transmitter: FSM encoding, register map and STATUS layout.
// Optional build macro UART_TX_PARITY_EN adds an even-parity state to the frame.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;
`endif

  // Byte offsets inside the 8-byte register window; only bit 2 is decoded.
  localparam logic [2:0] REG_TXDATA = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;
  localparam int unsigned STAT_CNT_W   = 4;

  function automatic logic [31:0] status_word(input logic full, input logic empty,
                                              input logic busy, input logic ovf,
                                              input logic [STAT_CNT_W-1:0] cnt);
    logic [31:0] w;
    w = '0;
    w[STAT_FULL]  = full;
    w[STAT_EMPTY] = empty;
    w[STAT_BUSY]  = busy;
    w[STAT_OVF]   = ovf;
    w[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth, wrapping pointers and an occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS register window, byte FIFO and serial framer.
// Define UART_TX_PARITY_EN to append an even-parity bit (11-bit frame); default is 8N1.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        sel,
  output logic        tx
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);

  tx_state_e       state;
  logic [BW-1:0]   baud;
  logic [2:0]      bit_idx;
  logic [7:0]      data_q;
  logic            ovf;

  logic            is_status_c;
  logic            wr_txdata_c;
  logic            wr_status_c;
  logic            baud_last_c;
  logic            pop_c;
  logic            line_c;
  logic            busy_c;
  logic [7:0]      fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            unused_c;

  assign unused_c = ^{addr[1:0], data_i[31:8]};

  // Address decode and register strobes.
  assign sel         = (addr[31:3] == BASE_ADDR[31:3]);
  assign is_status_c = (addr[2] == REG_STATUS[2]);
  assign wr_txdata_c = we && sel && (addr[2] == REG_TXDATA[2]);
  assign wr_status_c = we && sel && is_status_c;

  assign baud_last_c = (baud == BW'(CLKS_PER_BIT - 1));
  assign busy_c      = (state != ST_IDLE);
  assign pop_c       = !fifo_empty &&
                       ((state == ST_IDLE) || ((state == ST_STOP) && baud_last_c));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata_c),
    .pop   (pop_c),
    .din   (data_i[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Zero-latency read path, like the data memory it sits beside.
  always_comb begin
    data_o = '0;
    if (sel && is_status_c)
      data_o = status_word(fifo_full, fifo_empty, busy_c, ovf, STAT_CNT_W'(fifo_count));
  end

  // Sticky overflow: a dropped push sets it, any STATUS write clears it.
  always_ff @(posedge clk) begin
    if (!reset)
      ovf <= 1'b0;
    else if (wr_status_c)
      ovf <= 1'b0;
    else if (wr_txdata_c && fifo_full && !pop_c)
      ovf <= 1'b1;
  end

  always_comb begin
    line_c = 1'b1;
    case (state)
      ST_START:  line_c = 1'b0;
      ST_DATA:   line_c = data_q[bit_idx];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: line_c = ^data_q;
`endif
      default:   line_c = 1'b1;
    endcase
  end

  // Framer; tx is the registered copy of the current state's line level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      data_q  <= '0;
      tx      <= 1'b1;
    end else begin
      tx <= line_c;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            data_q <= fifo_dout;
            baud   <= '0;
            state  <= ST_START;
          end
        end
        ST_START: begin
          if (baud_last_c) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= ST_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_last_c) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_last_c) begin
            baud  <= '0;
            state <= ST_STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (baud_last_c) begin
            baud <= '0;
            if (!fifo_empty) begin
              data_q <= fifo_dout;
              state  <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: directed MMIO stores, a serial-line decoder that
// pops expected bytes, plus directed STATUS/timing checks.
module tb_mmio_uart_tx;

  localparam int CPB = 16;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] STAT = 32'h0000_1004;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        sel;
  logic        tx;

  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [7:0]  exp_q[$];
  bit          drop_frame = 1'b0;

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .addr   (addr),
    .data_i (data_i),
    .data_o (data_o),
    .sel    (sel),
    .tx     (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endfunction

  // Expected line level k clocks after the pushing edge, transmitter idle and empty.
  function automatic logic exp_line(input logic [7:0] b, input int k);
    int idx;
    if (k < 2) return 1'b1;
    idx = (k - 2) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; data_i = d;
    @(negedge clk);
    we = 1'b0; addr = STAT;
  endtask

  // Single frame from idle: exact waveform, busy window and frame length.
  task automatic frame_check(input logic [7:0] b);
    int bad_w;
    int bad_b;
    bad_w = -1;
    bad_b = -1;
    exp_q.push_back(b);
    push(BASE, {24'h0, b});
    for (int k = 1; k <= FB*CPB + 2; k++) begin
      @(negedge clk);
      if (tx !== exp_line(b, k) && bad_w < 0) bad_w = k;
      if (data_o[2] !== (k <= FB*CPB) && bad_b < 0) bad_b = k;
    end
    check($sformatf("wave_%02h first bad clock", b), bad_w, -1);
    check($sformatf("busy_%02h first bad clock", b), bad_b, -1);
  endtask

  // Line decoder: samples mid-bit and scores each frame against the queue.
  initial begin : monitor
    logic       prev;
    logic       ok;
    logic [7:0] rx;
    logic [7:0] e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && tx === 1'b0) begin
        repeat (CPB/2 - 1) @(negedge clk);
        ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        if (tx !== ^rx) ok = 1'b0;
`endif
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
        prev = tx;
        if (drop_frame) begin
          drop_frame = 1'b0;
        end else if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_frame: got 0x%02h expected none", rx);
        end else begin
          e = exp_q.pop_front();
          check("rx_frame (byte, framing ok=1)", {rx, 7'h0, ok}, {e, 8'h01});
        end
      end else begin
        prev = tx;
      end
    end
  end

  initial begin : stim
    int t0;
    int bad;
    reset = 1'b0; we = 1'b0; addr = '0; data_i = '0;
    // Stores while reset is low must be ignored.
    @(negedge clk);
    we = 1'b1; addr = BASE; data_i = 32'h77;
    repeat (2) @(negedge clk);
    we = 1'b0; addr = STAT;
    #1;
    check("reset_tx", tx, 1);
    check("reset_status", data_o, 32'h2);
    check("reset_sel", sel, 1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_status", data_o, 32'h2);

    addr = BASE; #1;
    check("txdata_read_sel", sel, 1);
    check("txdata_read_data", data_o, 0);
    addr = BASE + 32'h8; #1;
    check("outside_plus8_sel", sel, 0);
    check("outside_plus8_data", data_o, 0);
    addr = 32'h0; #1;
    check("outside_zero_sel", sel, 0);
    check("outside_zero_data", data_o, 0);

    push(BASE + 32'h8, 32'h99);
    push(32'h0, 32'h98);
    #1;
    check("outside_store_status", data_o, 32'h2);
    bad = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 && bad < 0) bad = k;
    end
    check("outside_store_tx_idle first bad", bad, -1);

    frame_check(8'h55);

    // Burst of five while the first byte is on the line: fifth one overflows.
    exp_q.push_back(8'hC3);
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    push(BASE, 32'hC3);
    t0 = cyc;
    we = 1'b1; addr = BASE;
    for (int i = 1; i <= 5; i++) begin
      data_i = 32'(i);
      @(negedge clk);
    end
    we = 1'b0; addr = STAT; #1;
    check("overflow_status", data_o, 32'h4D);
    push(STAT, 32'hFFFF_FFFF);
    #1;
    check("ovf_clear_status", data_o, 32'h45);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (data_o[2] == 1'b0) break;
    end
    check("five_frames_no_gap clocks", cyc - t0, 1 + 5*FB*CPB);
    check("after_burst_status", data_o, 32'h2);

    // Abort mid-data; queued bytes must be discarded.
    push(BASE, 32'hA5);
    push(BASE, 32'h11);
    push(BASE, 32'h22);
    repeat (60) @(negedge clk);
    drop_frame = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_tx", tx, 1);
    check("abort_status", data_o, 32'h2);
    reset = 1'b1;
    bad = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 && bad < 0) bad = k;
    end
    check("abort_tx_stays_idle first bad", bad, -1);
    check("abort_queue_lost_status", data_o, 32'h2);

`ifdef UART_TX_PARITY_EN
    frame_check(8'h07);
`endif

    repeat (40) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16; clk cycles per serial bit (>=2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4; transmit FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_1000; byte base of the 8-byte register window.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port we  in  1  store strobe from core data port (MemWE).
REQ-007 SHALL have port addr  in  32  data address from core (mem_addr).
REQ-008 SHALL have port data_i  in  32  store data from core (data_out_to_mem).
REQ-009 SHALL have port data_o  out  32  read data to core read-data mux.
REQ-010 SHALL have port sel  out  1  high when addr hits the window; core side uses it to mux data_o over DataMem.
REQ-011 SHALL have port tx  out  1  serial line, idle high.

Function
REQ-012 SHALL decode sel = (addr[31:3] == BASE_ADDR[31:3]), combinational; offset = addr[2].
REQ-013 SHALL treat offset 0 as TXDATA: we && sel pushes data_i[7:0] into FIFO at the clock edge; reads return 0.
REQ-014 SHALL treat offset 4 as STATUS (read): bit0 full, bit1 empty, bit2 busy, bit3 overflow, bits[7:4] count, others 0.
REQ-015 SHALL drive data_o combinationally from addr and current state (zero-latency read, matching DataMem); data_o = 0 when sel low.
REQ-016 SHALL drop a push while full, leave FIFO unchanged, and set sticky overflow.
REQ-017 SHALL clear overflow on any write with sel && offset 4, data ignored.
REQ-018 SHALL, on a cycle with simultaneous push and pop while full, accept both (count unchanged, no overflow).
REQ-019 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-020 SHALL implement FSM IDLE, START, DATA, STOP: IDLE pops when FIFO non-empty and enters START next cycle; START drives 0 for CLKS_PER_BIT cycles; DATA drives bits 0..7 LSB first, CLKS_PER_BIT cycles each; STOP drives 1 for CLKS_PER_BIT cycles, then IDLE, or START directly (popping next byte) if FIFO non-empty.
REQ-021 SHALL register tx (glitch-free); first start-bit cycle is 2 clocks after the pushing edge when idle and empty.
REQ-022 SHALL assert busy whenever FSM != IDLE.
REQ-023 SHALL use a baud counter of width clog2(CLKS_PER_BIT) and a 3-bit bit index; no other timing source.

Reset
REQ-024 SHALL, with reset low at a rising edge: FSM=IDLE, FIFO empty (pointers, count = 0), overflow=0, baud counter=0, tx=1.
REQ-025 SHALL abort any in-flight frame on reset mid-transmission; tx returns to 1 the cycle after the reset edge.
REQ-026 SHALL ignore we while reset is low.

Configuration
REQ-027 SHALL support macro UART_TX_PARITY_EN: when defined, FSM adds PARITY state between DATA and STOP sending even parity (XOR of 8 data bits) for CLKS_PER_BIT cycles; frame is 11 bits.
REQ-028 SHALL, without UART_TX_PARITY_EN, send 8N1 (10-bit frame) and contain no parity logic.

Structure
REQ-029 SHALL take the FSM state encoding, register offsets (TXDATA=0, STATUS=4) and STATUS bit positions from shared package uart_pkg.
REQ-030 SHALL instantiate FIFO storage as sub-module sync_fifo (parameters WIDTH=8, DEPTH; ports push, pop, din, dout, full, empty, count).

Verification
REQ-031 SHALL cover: store 8'h55 to BASE_ADDR, CLKS_PER_BIT=16 -> tx start bit 2 clocks later, bits 1,0,1,0,1,0,1,0, stop; frame 160 clocks; busy high throughout.
REQ-032 SHALL cover: 5 back-to-back stores (0x01..0x05), DEPTH=4, none popped yet -> STATUS reads full=1, overflow=1, count=4; 0x01..0x04 sent with no idle gap between frames.
REQ-033 SHALL cover: store to BASE_ADDR+4 after overflow -> overflow=0, FIFO contents unchanged.
REQ-034 SHALL cover: reset low mid-DATA of 8'hA5 -> next cycle tx=1, STATUS = 32'h0000_0002, queued bytes lost.
REQ-035 SHALL cover: read at BASE_ADDR+8 or 32'h0 -> sel=0, data_o=0; store there leaves FIFO unchanged.
REQ-036 SHALL cover, with UART_TX_PARITY_EN: send 8'h07 -> parity bit 1 after bit 7, frame 176 clocks.
